// File: rtl/bus_source_driver_pkg.sv
// -----------------------------------------------------------------------------
// bus_source_driver_pkg
//
// Shared definitions for the bus source driver slice:
//   WORD_W      - width of one bus word / one source register
//   MAX_SRC     - largest number of sources the one-hot helper accepts
//   state_t     - handshake FSM states (IDLE, VALID)
//   is_onehot() - true when exactly one bit of a select vector is set
// -----------------------------------------------------------------------------
package bus_source_driver_pkg;

    localparam int WORD_W  = 32;
    localparam int MAX_SRC = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic is_onehot(input logic [MAX_SRC-1:0] v);
        return (v != '0) && ((v & (v - MAX_SRC'(1))) == '0);
    endfunction

endpackage : bus_source_driver_pkg

// File: rtl/bus_source_driver_onehot_encoder.sv
// -----------------------------------------------------------------------------
// onehot_encoder
//
// Converts the NSRC-bit source-select vector into a binary index.
// The lowest set bit always provides the index, so a legal one-hot input
// encodes to its bit position and a multi-hot input (when the caller chooses
// to accept it) resolves to the lowest requester.  Flags report the
// zero-hot and multi-hot cases so the caller can apply its own policy.
//
// Ports:
//   i_vec    [NSRC-1:0]  select vector (register "out" strobes)
//   o_idx    [IDX_W-1:0] position of the lowest set bit (0 when none)
//   o_zero               no bit set
//   o_multi              more than one bit set
// -----------------------------------------------------------------------------
module onehot_encoder
    import bus_source_driver_pkg::*;
#(
    parameter int NSRC  = 8,
    parameter int IDX_W = $clog2(NSRC)
) (
    input  logic [NSRC-1:0]  i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_zero,
    output logic             o_multi
);

    logic w_onehot;

    // Scan high to low so the last match, and therefore the winner, is the
    // lowest set bit.
    // NOTE: every combinational output gets a default before any conditional
    // assignment; otherwise the tool infers a latch to hold the old value.
    always_comb begin
        o_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign w_onehot = is_onehot(MAX_SRC'(i_vec));
    assign o_zero   = ~|i_vec;
    assign o_multi  = ~o_zero & ~w_onehot;

endmodule : onehot_encoder

// File: rtl/bus_source_driver.sv
// -----------------------------------------------------------------------------
// bus_source_driver
//
// Read side of the shared 32-bit datapath bus.  On a request in IDLE the
// one-hot source select is encoded, the chosen source word is captured into
// an output register and presented on the bus with bus_valid high until the
// consumer acknowledges it.  The captured word and its index stay frozen for
// the whole VALID phase and remain on the bus after retirement.
//
// Optional feature (compile-time macro BUS_PRIORITY_EN):
//   defined   - multi-hot select is accepted, lowest set bit wins; only an
//               all-zero select raises sel_err.
//   undefined - any select that is not exactly one-hot raises sel_err and
//               no transfer takes place.
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   src_data   NSRC flattened source words, source i at [32*i+31:32*i]
//   rout       one-hot source select
//   req        transfer request (looked at in IDLE only)
//   ack        consumer has taken the word (looked at in VALID only)
//   bus        captured bus word
//   bus_valid  bus holds a word that has not yet been acknowledged
//   src_idx    encoded index of the captured source
//   sel_err    one-cycle pulse after a request with an illegal select
// -----------------------------------------------------------------------------
module bus_source_driver
    import bus_source_driver_pkg::*;
#(
    parameter int NSRC  = 8,
    parameter int IDX_W = $clog2(NSRC)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [NSRC*WORD_W-1:0] src_data,
    input  logic [NSRC-1:0]        rout,
    input  logic                   req,
    input  logic                   ack,
    output logic [WORD_W-1:0]      bus,
    output logic                   bus_valid,
    output logic [IDX_W-1:0]       src_idx,
    output logic                   sel_err
);

`ifdef BUS_PRIORITY_EN
    localparam bit MULTI_IS_ERR = 1'b0;
`else
    localparam bit MULTI_IS_ERR = 1'b1;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WORD_W-1:0]  r_bus;
    logic [IDX_W-1:0]   r_src_idx;
    logic               r_sel_err;

    logic [IDX_W-1:0]   w_idx;
    logic               w_zero;
    logic               w_multi;
    logic               w_legal;
    logic [WORD_W-1:0]  w_word;
    logic               w_capture;
    logic               w_sel_err_nxt;

    onehot_encoder #(
        .NSRC  (NSRC),
        .IDX_W (IDX_W)
    ) u_encoder (
        .i_vec   (rout),
        .o_idx   (w_idx),
        .o_zero  (w_zero),
        .o_multi (w_multi)
    );

    // A select is usable when something is hot and, unless priority mode is
    // built in, nothing else is hot alongside it.
    assign w_legal = ~w_zero & ~(w_multi & MULTI_IS_ERR);

    // w_idx only reaches an unused high code when the select is illegal, and
    // then the word is never captured.
    assign w_word = src_data[WORD_W*int'(w_idx) +: WORD_W];

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req && w_legal) begin
                    w_state_nxt = ST_VALID;
                end
            end
            ST_VALID: begin
                // ack wins over a simultaneous req; the requester retries
                // once the driver is back in IDLE.
                if (ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: output decode (controls for the output register)
    // ---------------------------------------------------------------------
    always_comb begin
        w_capture     = 1'b0;
        w_sel_err_nxt = 1'b0;
        if (r_state == ST_IDLE && req) begin
            w_capture     = w_legal;
            w_sel_err_nxt = ~w_legal;
        end
    end

    // ---------------------------------------------------------------------
    // Output register: word and index captured once per transfer
    // ---------------------------------------------------------------------
    // NOTE: these are a handful of output flops, not a memory, so they take
    // the asynchronous reset and clear as soon as clr falls.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_bus     <= '0;
            r_src_idx <= '0;
            r_sel_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_bus     <= w_word;
                r_src_idx <= w_idx;
            end
            r_sel_err <= w_sel_err_nxt;
        end
    end

    assign bus       = r_bus;
    assign src_idx   = r_src_idx;
    assign sel_err   = r_sel_err;
    assign bus_valid = (r_state == ST_VALID);

endmodule : bus_source_driver

// File: tb/tb_bus_source_driver.sv
// -----------------------------------------------------------------------------
// tb_bus_source_driver
//
// Directed bench for bus_source_driver (NSRC = 8).  Inputs change 1 time unit
// after each rising edge and outputs are sampled at the same point, well away
// from the active edge.  Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_bus_source_driver;

    localparam int NSRC  = 8;
    localparam int IDX_W = 3;

    logic                clk;
    logic                clr;
    logic [NSRC*32-1:0]  src_data;
    logic [NSRC-1:0]     rout;
    logic                req;
    logic                ack;
    logic [31:0]         bus;
    logic                bus_valid;
    logic [IDX_W-1:0]    src_idx;
    logic                sel_err;

    int n_pass  = 0;
    int n_total = 0;

    bus_source_driver #(
        .NSRC  (NSRC),
        .IDX_W (IDX_W)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .src_data  (src_data),
        .rout      (rout),
        .req       (req),
        .ack       (ack),
        .bus       (bus),
        .bus_valid (bus_valid),
        .src_idx   (src_idx),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [31:0] w);
        src_data[32*i +: 32] = w;
    endtask

    initial begin
        clr      = 1'b0;
        rout     = 8'h04;
        req      = 1'b1;
        ack      = 1'b0;
        src_data = '0;
        for (int i = 0; i < NSRC; i++) set_src(i, 32'h1111_1111 * i);
        set_src(3, 32'hDEAD_BEEF);

        // ---- reset held with an active request ----
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_bus",       bus,       32'h0);
            check("rst_bus_valid", 32'(bus_valid), 32'h0);
            check("rst_src_idx",   32'(src_idx),   32'h0);
            check("rst_sel_err",   32'(sel_err),   32'h0);
        end

        clr  = 1'b1;
        req  = 1'b0;
        rout = 8'h00;
        step();
        check("idle_valid", 32'(bus_valid), 32'h0);
        check("idle_err",   32'(sel_err),   32'h0);

        // ---- basic read of source 3 ----
        rout = 8'h08;
        req  = 1'b1;
        step();
        req  = 1'b0;
        check("rd_bus",   bus,             32'hDEAD_BEEF);
        check("rd_idx",   32'(src_idx),   32'd3);
        check("rd_valid", 32'(bus_valid), 32'h1);
        for (int k = 0; k < 5; k++) begin
            set_src(3, ~src_data[32*3 +: 32]);
            rout = 8'h01 << k;
            req  = k[0];
            step();
            check("hold_bus",   bus,             32'hDEAD_BEEF);
            check("hold_idx",   32'(src_idx),   32'd3);
            check("hold_valid", 32'(bus_valid), 32'h1);
        end
        req = 1'b0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("ret_valid", 32'(bus_valid), 32'h0);
        check("ret_bus",   bus,             32'hDEAD_BEEF);
        check("ret_idx",   32'(src_idx),   32'd3);
        set_src(3, 32'h3333_3333);

        // ---- ack in IDLE is ignored ----
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("idle_ack_valid", 32'(bus_valid), 32'h0);
        check("idle_ack_bus",   bus,             32'hDEAD_BEEF);

        // ---- all-zero select ----
        rout = 8'h00;
        req  = 1'b1;
        step();
        req  = 1'b0;
        check("zero_err",   32'(sel_err),   32'h1);
        check("zero_valid", 32'(bus_valid), 32'h0);
        check("zero_bus",   bus,             32'hDEAD_BEEF);
        step();
        check("zero_err_pulse", 32'(sel_err), 32'h0);

        // ---- multi-hot select 8'h12 ----
        rout = 8'h12;
        req  = 1'b1;
        step();
        req  = 1'b0;
`ifdef BUS_PRIORITY_EN
        check("multi_err",   32'(sel_err),   32'h0);
        check("multi_valid", 32'(bus_valid), 32'h1);
        check("multi_bus",   bus,             32'h1111_1111);
        check("multi_idx",   32'(src_idx),   32'd1);
        ack = 1'b1;
        step();
        ack = 1'b0;
`else
        check("multi_err",   32'(sel_err),   32'h1);
        check("multi_valid", 32'(bus_valid), 32'h0);
        check("multi_bus",   bus,             32'hDEAD_BEEF);
        check("multi_idx",   32'(src_idx),   32'd3);
        step();
`endif
        check("multi_err_pulse", 32'(sel_err), 32'h0);

        // ---- req and ack together in VALID: ack wins ----
        rout = 8'h04;
        req  = 1'b1;
        step();
        check("sim_cap_bus", bus, 32'h2222_2222);
        rout = 8'h80;
        ack  = 1'b1;
        step();
        ack  = 1'b0;
        check("sim_valid", 32'(bus_valid), 32'h0);
        check("sim_bus",   bus,             32'h2222_2222);
        check("sim_idx",   32'(src_idx),   32'd2);
        step();
        req  = 1'b0;
        check("retry_bus",   bus,             32'h7777_7777);
        check("retry_idx",   32'(src_idx),   32'd7);
        check("retry_valid", 32'(bus_valid), 32'h1);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // ---- asynchronous reset mid-transfer ----
        set_src(5, 32'h0000_00FF);
        rout = 8'h20;
        req  = 1'b1;
        step();
        req  = 1'b0;
        check("ar_pre_bus", bus, 32'h0000_00FF);
        #2;
        clr = 1'b0;
        #1;
        check("ar_bus",   bus,             32'h0);
        check("ar_valid", 32'(bus_valid), 32'h0);
        check("ar_idx",   32'(src_idx),   32'h0);
        #2;
        clr = 1'b1;
        step();
        check("ar_rel_valid", 32'(bus_valid), 32'h0);
        set_src(5, 32'h5555_5555);

        // ---- sweep every source ----
        for (int i = 0; i < NSRC; i++) begin
            rout = 8'h01 << i;
            req  = 1'b1;
            step();
            req  = 1'b0;
            check("sw_bus",   bus,             32'h1111_1111 * i);
            check("sw_idx",   32'(src_idx),   32'(i));
            check("sw_valid", 32'(bus_valid), 32'h1);
            ack = 1'b1;
            step();
            ack = 1'b0;
            check("sw_ret", 32'(bus_valid), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_bus_source_driver
